fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and replaces the bare PC register feeding it.
- Owns the fetch PC and drives the byte-addressed instruction memory read address.
- Buffers fetched {instruction, pc_next} pairs in a small FIFO, so ID stalls do not lose fetch bandwidth.
- A taken branch or jump resolved in ID flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
PTR_W, 2, pointer width, log2(DEPTH)
RESET_PC, 32'h00000000, fetch PC loaded on reset

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  synchronous, active-high reset
imem_addr  output  32  byte address to instruction memory; always equals fetch_pc
imem_rdata  input  32  instruction word at imem_addr; combinational, little-endian bytes assembled by memory
redirect  input  1  taken branch/jump from ID (pc_src asserted)
redirect_pc  input  32  target address from the decode-address unit
id_stall  input  1  ID/hazard stall; when 1, the head entry is not consumed
instr_out  output  32  head-entry instruction to IF/ID; 32'h00000000 (nop) when empty
pc_next_out  output  32  head-entry PC+4 to IF/ID; 0 when empty
valid_out  output  1  queue non-empty
count_out  output  PTR_W+1  occupancy, 0..DEPTH

Behaviour:
- Reset (synchronous, reset=1 at rising edge) loads the following, and takes priority over every other input, including mid-operation:
  - fetch_pc = RESET_PC
  - rd_ptr = wr_ptr = 0, count = 0
  - instr_out = 0, pc_next_out = 0, valid_out = 0, count_out = 0
- Outputs are combinational from registered state only:
  - instr_out/pc_next_out = mem[rd_ptr] when count>0, else 0
  - valid_out = (count != 0); count_out = count
- pop = valid_out & ~id_stall & ~redirect.
- push = ~redirect & ((count < DEPTH) | pop). When full, a same-cycle pop frees the slot.
- On push:
  - mem[wr_ptr] = {imem_rdata, fetch_pc+4}
  - wr_ptr++ (wraps modulo DEPTH)
  - fetch_pc = fetch_pc+4
- On pop: rd_ptr++ (wraps modulo DEPTH).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Redirect: highest priority after reset.
  - Clears count and both pointers.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
  - No push and no pop that cycle; redirect wins over id_stall.
  - The next cycle the queue is empty (valid_out=0, nop bubble). The target instruction appears on instr_out one cycle after that.
- Latency: the first instruction after reset release is visible on instr_out after the first rising edge with reset=0. Steady state without stalls: one instruction per cycle, and count stays at 1.
- fetch_pc arithmetic is 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0.
- While full and stalled: fetch_pc holds and imem_addr is stable.
- imem_rdata is sampled only on push cycles; the content is not checked (zero words are nops).

Test Plan:
- Reset/first fetch: hold reset 2 cycles with imem[0]=32'h20080001 → during reset count_out=0, valid_out=0, instr_out=0. First edge after release → instr_out=32'h20080001, pc_next_out=4, imem_addr=4.
- Streaming: program words 0..10 with id_stall=0 → instr_out sequence matches words 0,1,2,..., pc_next_out = 4,8,12,..., count_out=1 each cycle.
- Stall fill: id_stall=1 for 6 cycles from PC 0 → count_out climbs to 4 and holds, imem_addr holds at 16, head stays 32'h20080001. Release → entries drain in order, no duplicates or drops.
- Redirect: BEQ 32'h11090001 at addr 32 reaches the head, then redirect=1, redirect_pc=40 → next cycle valid_out=0, count_out=0. The following cycle instr_out=32'h200A0005, pc_next_out=44. Word at 36 (32'h200A0063) is never output.
- Redirect with stall and full queue: count=4, id_stall=1, redirect=1, redirect_pc=32'h0000002B → queue empties, imem_addr=32'h00000028.
- Wrap/reset mid-run: redirect to 32'hFFFFFFFC → next fetch imem_addr=0. Assert reset with count=3 → all outputs 0 next cycle, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory, redirect and IF/ID-facing signals of the fetch front end
interface fetch_queue_if #(parameter int PTR_W = 2);
    logic [31:0]    imem_addr;
    logic [31:0]    imem_rdata;
    logic           redirect;
    logic [31:0]    redirect_pc;
    logic           id_stall;
    logic [31:0]    instr_out;
    logic [31:0]    pc_next_out;
    logic           valid_out;
    logic [PTR_W:0] count_out;
    modport master (
        output imem_addr, instr_out, pc_next_out, valid_out, count_out,
        input  imem_rdata, redirect, redirect_pc, id_stall
    );
    modport slave (
        input  imem_addr, instr_out, pc_next_out, valid_out, count_out,
        output imem_rdata, redirect, redirect_pc, id_stall
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner plus a small FIFO of {instruction, pc+4} pairs feeding IF/ID
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    logic [63:0]    mem_q [DEPTH];
    logic [63:0]    mem_d [DEPTH];
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    logic           valid, push, pop;
    assign valid           = count_q != '0;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.valid_out   = valid;
    assign bus.count_out   = count_q;
    assign bus.instr_out   = valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
    assign bus.pc_next_out = valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    always_comb begin
        pop        = valid & ~bus.id_stall & ~bus.redirect;
        push       = ~bus.redirect & ((count_q != FULL) | pop);
        fetch_pc_d = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} :
                     push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        wr_ptr_d   = bus.redirect ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = bus.redirect ? '0 : rd_ptr_q + PTR_W'(pop);
        count_d    = bus.redirect ? '0 : count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q] = {bus.imem_rdata, fetch_pc_q + 32'd4};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against hand-computed values
module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    fetch_queue_if #(.PTR_W(2)) bus ();
    fetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'd0:          prog = 32'h20080001;
            32'd32:         prog = 32'h11090001;
            32'd36:         prog = 32'h200A0063;
            32'd40:         prog = 32'h200A0005;
            32'hFFFFFFFC:   prog = 32'hDEADBEEF;
            default:        prog = (a < 32'd64) ? 32'h20100000 + a : 32'h0;
        endcase
    endfunction
    assign bus.imem_rdata = prog(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] instr, input logic [31:0] pcn,
                            input logic [31:0] cnt);
        chk({tag, "_instr"}, bus.instr_out, instr);
        chk({tag, "_pcn"}, bus.pc_next_out, pcn);
        chk({tag, "_cnt"}, 32'(bus.count_out), cnt);
        chk({tag, "_valid"}, 32'(bus.valid_out), 32'(cnt != 0));
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step;
            chk_head("reset", 32'h0, 32'h0, 0);
            chk("reset_addr", bus.imem_addr, 32'h0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step;
            chk_head("stream", prog(32'(4 * (k - 1))), 32'(4 * k), 1);
            chk("stream_addr", bus.imem_addr, 32'(4 * k));
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        step;
        chk_head("restart", 32'h0, 32'h0, 0);
        chk("restart_addr", bus.imem_addr, 32'h0);
        bus.redirect = 1'b0;
        bus.id_stall = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step;
            chk_head("fill", 32'h20080001, 32'd4, (j < 4) ? j : 4);
            chk("fill_addr", bus.imem_addr, 32'(4 * ((j < 4) ? j : 4)));
        end
        bus.id_stall = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step;
            chk_head("drain", prog(32'(4 * j)), 32'(4 * (j + 1)), 4);
        end
        chk("beq_head", bus.instr_out, 32'h11090001);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'd40;
        step;
        chk_head("redir", 32'h0, 32'h0, 0);
        chk("redir_addr", bus.imem_addr, 32'd40);
        bus.redirect = 1'b0;
        step;
        chk_head("target", 32'h200A0005, 32'd44, 1);
        bus.id_stall = 1'b1;
        for (int j = 0; j < 3; j++) step;
        chk_head("full", 32'h200A0005, 32'd44, 4);
        chk("full_addr", bus.imem_addr, 32'd56);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000002B;
        step;
        chk_head("redir_full", 32'h0, 32'h0, 0);
        chk("redir_full_addr", bus.imem_addr, 32'h00000028);
        bus.id_stall = 1'b0;
        bus.redirect_pc = 32'hFFFFFFFC;
        step;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFFFFFC);
        bus.redirect = 1'b0;
        step;
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk_head("wrap", 32'hDEADBEEF, 32'h0, 1);
        bus.id_stall = 1'b1;
        for (int j = 0; j < 2; j++) step;
        chk("pre_reset_cnt", 32'(bus.count_out), 32'd3);
        reset = 1'b1;
        step;
        chk_head("midreset", 32'h0, 32'h0, 0);
        chk("midreset_addr", bus.imem_addr, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
